wb_port_arbiter: RTL and testbench

WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

---
 rtl/wb_port_arbiter.sv | 79 +++++++
 tb/tb_wb_port_arbiter.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/wb_port_arbiter.sv
// Two-requester register-file write-port arbiter with round-robin tie-breaking.
// Grants are combinational; the resulting write appears registered one cycle later.
module wb_port_arbiter #(
    parameter int unsigned DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_a,
    input  logic [4:0]    addr_a,
    input  logic [DW-1:0] data_a,
    input  logic          req_b,
    input  logic [4:0]    addr_b,
    input  logic [DW-1:0] data_b,
    input  logic          hold,
    output logic          gnt_a,
    output logic          gnt_b,
    output logic          wr_en,
    output logic [4:0]    wr_addr,
    output logic [DW-1:0] wr_data,
    output logic [7:0]    conflict_cnt
);

    localparam int unsigned AW = 5;
    localparam int unsigned CW = 8;

    typedef enum logic {IDLE, WRITE} state_t;

    state_t state;
    logic   last_b;     // 1 when B received the most recent grant
    logic   eligible;
    logic   tie;

    // Grant decision: the side not granted most recently wins a tie
    always_comb begin
        eligible = 1'b0;
        gnt_a    = 1'b0;
        gnt_b    = 1'b0;
        tie      = req_a && req_b && !hold;
        eligible = !rst && !hold && (state == IDLE || state == WRITE);
        gnt_a    = eligible && req_a && (!req_b || last_b);
        gnt_b    = eligible && req_b && (!req_a || !last_b);
    end

    // Write-port FSM and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            last_b  <= 1'b0;
            wr_en   <= 1'b0;
            wr_addr <= AW'(0);
            wr_data <= DW'(0);
        end else if (gnt_a) begin
            state   <= WRITE;
            last_b  <= 1'b0;
            wr_en   <= (addr_a != AW'(0));
            wr_addr <= addr_a;
            wr_data <= data_a;
        end else if (gnt_b) begin
            state   <= WRITE;
            last_b  <= 1'b1;
            wr_en   <= (addr_b != AW'(0));
            wr_addr <= addr_b;
            wr_data <= data_b;
        end else begin
            state   <= IDLE;
            wr_en   <= 1'b0;
        end
    end

    // Saturating count of contended, unfrozen cycles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            conflict_cnt <= CW'(0);
        end else if (tie && conflict_cnt != {CW{1'b1}}) begin
            conflict_cnt <= conflict_cnt + CW'(1);
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: a reference model predicts each grant and
// queues the expected write, which is popped and compared a cycle later.
module tb_wb_port_arbiter;

    localparam int unsigned DW = 32;

    typedef struct packed {
        logic          en;
        logic [4:0]    addr;
        logic [DW-1:0] data;
    } wr_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_a, req_b, hold;
    logic [4:0]    addr_a, addr_b;
    logic [DW-1:0] data_a, data_b;
    logic          gnt_a, gnt_b, wr_en;
    logic [4:0]    wr_addr;
    logic [DW-1:0] wr_data;
    logic [7:0]    conflict_cnt;

    int checks = 0;
    int failures = 0;

    wr_t q[$];
    logic          m_last_b;
    logic [4:0]    m_addr;
    logic [DW-1:0] m_data;
    int            m_cnt;

    wb_port_arbiter #(.DW(DW)) dut (
        .clk(clk), .rst(rst),
        .req_a(req_a), .addr_a(addr_a), .data_a(data_a),
        .req_b(req_b), .addr_b(addr_b), .data_b(data_b),
        .hold(hold),
        .gnt_a(gnt_a), .gnt_b(gnt_b),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .conflict_cnt(conflict_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_last_b = 1'b0;
        m_addr   = '0;
        m_data   = '0;
        m_cnt    = 0;
        q.delete();
    endtask

    // One clock cycle: drive, check grants, predict the write, check it after the edge
    task automatic cycle(input logic ra, input logic [4:0] aa, input logic [DW-1:0] da,
                         input logic rb, input logic [4:0] ab, input logic [DW-1:0] db,
                         input logic h, input string tag);
        logic ega, egb;
        wr_t  exp_w, got_w;
        @(negedge clk);
        req_a = ra; addr_a = aa; data_a = da;
        req_b = rb; addr_b = ab; data_b = db;
        hold = h;
        #1;
        ega = !h && ra && (!rb || m_last_b);
        egb = !h && rb && (!ra || !m_last_b);
        check({tag, ".gnt_a"}, DW'(gnt_a), DW'(ega));
        check({tag, ".gnt_b"}, DW'(gnt_b), DW'(egb));
        if (ega) begin
            m_addr = aa; m_data = da; m_last_b = 1'b0;
        end else if (egb) begin
            m_addr = ab; m_data = db; m_last_b = 1'b1;
        end
        exp_w.en   = (ega || egb) && (m_addr != 5'd0);
        exp_w.addr = m_addr;
        exp_w.data = m_data;
        q.push_back(exp_w);
        if (ra && rb && !h && m_cnt < 255) m_cnt++;
        @(posedge clk);
        #1;
        if (q.size() == 0) begin
            checks++; failures++;
            $error("FAIL %s.queue observed=empty expected=entry", tag);
        end else begin
            got_w = q.pop_front();
            check({tag, ".wr_en"},   DW'(wr_en),   DW'(got_w.en));
            check({tag, ".wr_addr"}, DW'(wr_addr), DW'(got_w.addr));
            check({tag, ".wr_data"}, wr_data,      got_w.data);
        end
        check({tag, ".cnt"}, DW'(conflict_cnt), DW'(m_cnt));
    endtask

    initial begin
        rst = 1'b1; hold = 1'b0;
        req_a = 1'b1; addr_a = 5'd3; data_a = 32'h1;
        req_b = 1'b1; addr_b = 5'd4; data_b = 32'h2;
        model_reset();
        #12;
        check("rst.gnt_a", DW'(gnt_a), DW'(0));
        check("rst.gnt_b", DW'(gnt_b), DW'(0));
        check("rst.wr_en", DW'(wr_en), DW'(0));
        check("rst.wr_addr", DW'(wr_addr), DW'(0));
        check("rst.wr_data", wr_data, DW'(0));
        check("rst.cnt", DW'(conflict_cnt), DW'(0));
        @(negedge clk);
        req_a = 1'b0; req_b = 1'b0;
        rst = 1'b0;

        // Tie after reset: expect B,A,B,A and four consecutive writes
        cycle(1, 5'd7, 32'hA000_0001, 1, 5'd9,  32'hB000_0001, 0, "tie0");
        check("tie0.is_b", DW'(m_last_b), DW'(1));
        cycle(1, 5'd7, 32'hA000_0001, 1, 5'd10, 32'hB000_0002, 0, "tie1");
        check("tie1.is_a", DW'(m_last_b), DW'(0));
        cycle(1, 5'd8, 32'hA000_0002, 1, 5'd10, 32'hB000_0002, 0, "tie2");
        cycle(1, 5'd8, 32'hA000_0002, 1, 5'd11, 32'hB000_0003, 0, "tie3");
        check("tie.cnt4", DW'(conflict_cnt), DW'(4));

        cycle(1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'h0, 0, "single_a");
        check("single_a.addr", DW'(wr_addr), DW'(5));
        check("single_a.data", wr_data, 32'hDEADBEEF);
        cycle(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, "idle");
        cycle(0, 5'd0, 32'h0, 1, 5'd0, 32'h5555_AAAA, 0, "zero_b");
        check("zero_b.wr_en", DW'(wr_en), DW'(0));
        cycle(0, 5'd0, 32'h0, 1, 5'd31, 32'h1234_5678, 0, "b_max");

        // Hold: three frozen cycles, then A granted once hold drops
        for (int i = 0; i < 3; i++) cycle(1, 5'd12, 32'hC0DE_0000, 0, 5'd0, 32'h0, 1, "hold");
        cycle(1, 5'd12, 32'hC0DE_0000, 0, 5'd0, 32'h0, 0, "hold_rel");
        check("hold_rel.wr_en", DW'(wr_en), DW'(1));
        cycle(1, 5'd13, 32'h1, 1, 5'd14, 32'h2, 1, "hold_tie");
        cycle(0, 5'd13, 32'h1, 0, 5'd14, 32'h2, 0, "dropped");

        // Reset in the WRITE cycle following an A grant
        cycle(1, 5'd6, 32'h6666_6666, 0, 5'd0, 32'h0, 0, "pre_rst");
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst.wr_en", DW'(wr_en), DW'(0));
        check("mid_rst.cnt", DW'(conflict_cnt), DW'(0));
        check("mid_rst.gnt_a", DW'(gnt_a), DW'(0));
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        cycle(1, 5'd1, 32'h11, 1, 5'd2, 32'h22, 0, "post_rst_tie");
        check("post_rst.addr", DW'(wr_addr), DW'(2));

        // Saturation of the conflict counter
        for (int i = 0; i < 300; i++) cycle(1, 5'd3, 32'h33, 1, 5'd4, 32'h44, 0, "sat");
        check("sat.cnt", DW'(conflict_cnt), DW'(255));

        @(negedge clk);
        req_a = 1'b0; req_b = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
